mc_fuse_loader: RTL and testbench

MC_FUSE_LOADER -- requirements
Module: mc_fuse_loader

---
 rtl/mc_fuse_loader_if.sv | 21 ++
 rtl/mc_fuse_loader.sv | 104 ++++++++++
 tb/tb_mc_fuse_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_fuse_loader_if.sv
// Serial fuse stream handshake between a fuse source and the macrocell loader.
interface mc_fuse_loader_if;
   logic start;
   logic fuse_bit;
   logic fuse_valid;
   logic fuse_ready;

   modport master (
      output start,
      output fuse_bit,
      output fuse_valid,
      input  fuse_ready
   );

   modport slave (
      input  start,
      input  fuse_bit,
      input  fuse_valid,
      output fuse_ready
   );
endinterface

// File: rtl/mc_fuse_loader.sv
// Macrocell fuse loader: shifts 501 serial fuse bits into a shadow register
// and commits them to the configuration outputs in one step.
module mc_fuse_loader #(
   parameter logic ERASED_VAL = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   mc_fuse_loader_if.slave   bus,
   output logic [0:479]      ptgroupbitmap_mux,
   output logic              pt1_mux,
   output logic              pt2_mux,
   output logic              pt3_mux,
   output logic              pt4_mux,
   output logic              pt5_mux,
   output logic              gclr_mux,
   output logic              pt4_func_mux,
   output logic              pt5_func_mux,
   output logic              xor_a_mux,
   output logic              xor_b_mux,
   output logic              xor_inv_mux,
   output logic              d_mux,
   output logic              dfast_mux,
   output logic              storage_mux,
   output logic              fb_mux,
   output logic              o_mux,
   output logic [0:2]        oe_mux,
   output logic [0:1]        gclk_mux,
   output logic              cfg_valid,
   output logic              busy,
   output logic              err_stray
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOAD   = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;
   localparam logic [8:0] LAST   = 9'd500;

   logic [1:0]   state;
   logic [8:0]   cnt;
   logic [0:500] shadow;
   logic [0:500] cfg;

   assign bus.fuse_ready = (state == LOAD);
   assign busy           = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         shadow    <= {501{ERASED_VAL}};
         cfg       <= {501{ERASED_VAL}};
         cfg_valid <= 1'b0;
         err_stray <= 1'b0;
      end else begin
         err_stray <= bus.fuse_valid && (state != LOAD);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state     <= LOAD;
                  cnt       <= '0;
                  cfg_valid <= 1'b0;
               end
            end
            LOAD: begin
               // a restart wins over a bit presented on the same edge
               if (bus.start) begin
                  cnt <= '0;
               end else if (bus.fuse_valid) begin
                  shadow[cnt] <= bus.fuse_bit;
                  if (cnt == LAST) begin
                     state <= COMMIT;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 9'd1;
                  end
               end
            end
            COMMIT: begin
               cfg       <= shadow;
               cfg_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ptgroupbitmap_mux = cfg[0:479];
   assign {pt1_mux, pt2_mux, pt3_mux, pt4_mux, pt5_mux} = cfg[480:484];
   assign gclr_mux     = cfg[485];
   assign pt4_func_mux = cfg[486];
   assign pt5_func_mux = cfg[487];
   assign xor_a_mux    = cfg[488];
   assign xor_b_mux    = cfg[489];
   assign xor_inv_mux  = cfg[490];
   assign d_mux        = cfg[491];
   assign dfast_mux    = cfg[492];
   assign storage_mux  = cfg[493];
   assign fb_mux       = cfg[494];
   assign o_mux        = cfg[495];
   assign oe_mux       = cfg[496:498];
   assign gclk_mux     = cfg[499:500];

endmodule

// File: tb/tb_mc_fuse_loader.sv
// Directed bench for mc_fuse_loader: reset, full, restart, gapped,
// stray-data and mid-load reset scenarios.
module tb_mc_fuse_loader;
   logic clk;
   logic rst_n;

   logic [0:479] ptgroupbitmap_mux;
   logic pt1_mux, pt2_mux, pt3_mux, pt4_mux, pt5_mux;
   logic gclr_mux, pt4_func_mux, pt5_func_mux;
   logic xor_a_mux, xor_b_mux, xor_inv_mux;
   logic d_mux, dfast_mux, storage_mux, fb_mux, o_mux;
   logic [0:2] oe_mux;
   logic [0:1] gclk_mux;
   logic cfg_valid, busy, err_stray;

   int total = 0;
   int bad   = 0;

   logic [0:500] all_one;
   logic [0:500] all_zero;
   logic [0:500] alt;

   mc_fuse_loader_if bus ();

   mc_fuse_loader #(.ERASED_VAL(1'b1)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .bus               (bus.slave),
      .ptgroupbitmap_mux (ptgroupbitmap_mux),
      .pt1_mux           (pt1_mux),
      .pt2_mux           (pt2_mux),
      .pt3_mux           (pt3_mux),
      .pt4_mux           (pt4_mux),
      .pt5_mux           (pt5_mux),
      .gclr_mux          (gclr_mux),
      .pt4_func_mux      (pt4_func_mux),
      .pt5_func_mux      (pt5_func_mux),
      .xor_a_mux         (xor_a_mux),
      .xor_b_mux         (xor_b_mux),
      .xor_inv_mux       (xor_inv_mux),
      .d_mux             (d_mux),
      .dfast_mux         (dfast_mux),
      .storage_mux       (storage_mux),
      .fb_mux            (fb_mux),
      .o_mux             (o_mux),
      .oe_mux            (oe_mux),
      .gclk_mux          (gclk_mux),
      .cfg_valid         (cfg_valid),
      .busy              (busy),
      .err_stray         (err_stray)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [0:500] outs();
      return {ptgroupbitmap_mux, pt1_mux, pt2_mux, pt3_mux, pt4_mux,
              pt5_mux, gclr_mux, pt4_func_mux, pt5_func_mux, xor_a_mux,
              xor_b_mux, xor_inv_mux, d_mux, dfast_mux, storage_mux,
              fb_mux, o_mux, oe_mux, gclk_mux};
   endfunction

   // mode 0: bit k = k%2, mode 1: all zero, mode 2: all one
   function automatic logic pat(input int k, input int mode);
      if (mode == 0) return k[0];
      return (mode == 2);
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // returns number of presented bits that saw fuse_ready low
   task automatic load_bits(input int n, input int mode, input bit gapped,
                            output int not_ready);
      not_ready = 0;
      for (int k = 0; k < n; k++) begin
         if (gapped) begin
            bus.fuse_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         bus.fuse_valid = 1'b1;
         bus.fuse_bit   = pat(k, mode);
         if (bus.fuse_ready !== 1'b1) not_ready++;
         @(negedge clk);
      end
      bus.fuse_valid = 1'b0;
      bus.fuse_bit   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.fuse_valid = 1'b0;
      bus.fuse_bit = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (outs() !== all_one) begin
         bad++; $display("FAIL reset_cfg got=%h exp=%h", outs(), all_one);
      end
      total++;
      if ({cfg_valid, busy, bus.fuse_ready, err_stray} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_flags got=%b exp=0000",
                  {cfg_valid, busy, bus.fuse_ready, err_stray});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL reset_idle busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_full_load();
      int nr;
      pulse_start();
      total++;
      if (busy !== 1'b1 || cfg_valid !== 1'b0) begin
         bad++;
         $display("FAIL full_start busy=%b cfg_valid=%b exp 1/0",
                  busy, cfg_valid);
      end
      load_bits(501, 0, 1'b0, nr);
      total++;
      if (nr != 0) begin
         bad++; $display("FAIL full_ready not_ready=%0d exp=0", nr);
      end
      total++;
      if (cfg_valid !== 1'b0 || bus.fuse_ready !== 1'b0 || busy !== 1'b1)
      begin
         bad++;
         $display("FAIL full_commit_state cv=%b rdy=%b busy=%b exp 0/0/1",
                  cfg_valid, bus.fuse_ready, busy);
      end
      @(negedge clk);
      total++;
      if (ptgroupbitmap_mux[0] !== 1'b0 || ptgroupbitmap_mux[1] !== 1'b1
          || gclk_mux !== 2'b10) begin
         bad++;
         $display("FAIL full_fields pt0=%b pt1=%b gclk=%b exp 0 1 10",
                  ptgroupbitmap_mux[0], ptgroupbitmap_mux[1], gclk_mux);
      end
      total++;
      if (outs() !== alt) begin
         bad++; $display("FAIL full_cfg got=%h exp=%h", outs(), alt);
      end
      total++;
      if (cfg_valid !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL full_done cfg_valid=%b busy=%b exp 1/0",
                  cfg_valid, busy);
      end
   endtask

   task automatic test_restart();
      int nr;
      pulse_start();
      load_bits(200, 2, 1'b0, nr);
      bus.start      = 1'b1;
      bus.fuse_valid = 1'b1;
      bus.fuse_bit   = 1'b1;
      @(negedge clk);
      bus.start      = 1'b0;
      bus.fuse_valid = 1'b0;
      total++;
      if (busy !== 1'b1 || outs() !== alt) begin
         bad++;
         $display("FAIL restart_hold busy=%b got=%h exp=%h",
                  busy, outs(), alt);
      end
      load_bits(501, 1, 1'b0, nr);
      total++;
      if (nr != 0 || cfg_valid !== 1'b0 || outs() !== alt) begin
         bad++;
         $display("FAIL restart_pre nr=%0d cv=%b got=%h exp cv=0 cfg=%h",
                  nr, cfg_valid, outs(), alt);
      end
      @(negedge clk);
      total++;
      if (outs() !== all_zero || cfg_valid !== 1'b1) begin
         bad++;
         $display("FAIL restart_cfg cv=%b got=%h exp=%h",
                  cfg_valid, outs(), all_zero);
      end
   endtask

   task automatic test_gapped();
      int nr;
      pulse_start();
      load_bits(501, 0, 1'b1, nr);
      total++;
      if (nr != 0 || busy !== 1'b1 || cfg_valid !== 1'b0) begin
         bad++;
         $display("FAIL gap_pre nr=%0d busy=%b cv=%b exp 0/1/0",
                  nr, busy, cfg_valid);
      end
      @(negedge clk);
      total++;
      if (outs() !== alt || cfg_valid !== 1'b1) begin
         bad++;
         $display("FAIL gap_cfg cv=%b got=%h exp=%h", cfg_valid, outs(), alt);
      end
   endtask

   task automatic test_stray();
      for (int i = 0; i < 3; i++) begin
         bus.fuse_valid = 1'b1;
         bus.fuse_bit   = 1'b0;
         @(negedge clk);
         total++;
         if (err_stray !== 1'b1 || busy !== 1'b0 || cfg_valid !== 1'b1
             || outs() !== alt) begin
            bad++;
            $display("FAIL stray_%0d err=%b busy=%b cv=%b got=%h exp 1/0/1",
                     i, err_stray, busy, cfg_valid, outs());
         end
      end
      bus.fuse_valid = 1'b0;
      @(negedge clk);
      total++;
      if (err_stray !== 1'b0) begin
         bad++; $display("FAIL stray_end err=%b exp=0", err_stray);
      end
   endtask

   task automatic test_reset_midload();
      int nr;
      pulse_start();
      load_bits(300, 1, 1'b0, nr);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (outs() !== all_one || cfg_valid !== 1'b0 || busy !== 1'b0
          || bus.fuse_ready !== 1'b0) begin
         bad++;
         $display("FAIL midrst cv=%b busy=%b rdy=%b got=%h exp=%h",
                  cfg_valid, busy, bus.fuse_ready, outs(), all_one);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.fuse_valid = 1'b1;
      bus.fuse_bit   = 1'b0;
      @(negedge clk);
      bus.fuse_valid = 1'b0;
      total++;
      if (err_stray !== 1'b1 || busy !== 1'b0 || outs() !== all_one) begin
         bad++;
         $display("FAIL midrst_stray err=%b busy=%b got=%h exp 1/0 %h",
                  err_stray, busy, outs(), all_one);
      end
   endtask

   initial begin
      all_one  = '1;
      all_zero = '0;
      for (int k = 0; k <= 500; k++) alt[k] = k[0];
      test_reset();
      test_full_load();
      test_restart();
      test_gapped();
      test_stray();
      test_reset_midload();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
